// File: rtl/inst_encoder_pkg.sv
// Shared ISA definitions: field widths, instruction word layout and the
// encoder's FSM state codes.
package inst_encoder_pkg;

    localparam int FIELD_W    = 4;
    localparam int INST_W     = 16;
    localparam int OPCODE_LSB = 12;
    localparam int SRC1_LSB   = 8;
    localparam int SRC2_LSB   = 4;
    localparam int DEST_LSB   = 0;

    typedef logic [FIELD_W-1:0] field_t;
    typedef logic [INST_W-1:0]  inst_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic inst_t pack_inst(
        input field_t opcode,
        input field_t srcadd_1,
        input field_t srcadd_2,
        input field_t destadd
    );
        inst_t word;
        word = '0;
        word[OPCODE_LSB +: FIELD_W] = opcode;
        word[SRC1_LSB   +: FIELD_W] = srcadd_1;
        word[SRC2_LSB   +: FIELD_W] = srcadd_2;
        word[DEST_LSB   +: FIELD_W] = destadd;
        return word;
    endfunction

endpackage

// File: rtl/inst_encoder_sync_fifo.sv
// Small first-word-fall-through FIFO; the head is readable while not empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (wr_ptr_reg == rd_ptr_reg);
    assign o_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_rdata = mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs instruction field sets into 16-bit words and streams them into
// instruction memory starting at a base address, one word per cycle.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_len,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_opcode,
    input  logic [3:0]        i_srcadd_1,
    input  logic [3:0]        i_srcadd_2,
    input  logic [3:0]        i_destadd,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] CNT_ONE = 1;

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] accepted_reg;
    logic [ADDR_W-1:0] popped_reg;
    logic [ADDR_W-1:0] written_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [INST_W-1:0] mem_wdata_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic [INST_W-1:0] fifo_head;
    logic [INST_W-1:0] packed_word;
    logic              accept;
    logic              pop;
    logic              last_commit;

    assign packed_word = pack_inst(i_opcode, i_srcadd_1, i_srcadd_2, i_destadd);
    assign o_ready     = (state_reg == ST_LOAD) && !fifo_full && (accepted_reg < len_reg);
    assign accept      = i_valid && o_ready;
    assign pop         = (state_reg == ST_LOAD) && !fifo_empty;
    // The final word leaves LOAD on the edge where memory captures it, so
    // o_done lands in the cycle after the last write strobe.
    assign last_commit = mem_we_reg && (written_reg == len_reg - CNT_ONE);

    sync_fifo #(
        .WIDTH (INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (accept),
        .i_wdata (packed_word),
        .i_pop   (pop),
        .o_rdata (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            base_reg     <= '0;
            len_reg      <= '0;
            accepted_reg <= '0;
            popped_reg   <= '0;
            written_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            state_reg    <= ST_LOAD;
                            base_reg     <= i_base_addr;
                            len_reg      <= i_len;
                            accepted_reg <= '0;
                            popped_reg   <= '0;
                            written_reg  <= '0;
                        end else begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept)     accepted_reg <= accepted_reg + CNT_ONE;
                    if (pop)        popped_reg   <= popped_reg + CNT_ONE;
                    if (mem_we_reg) written_reg  <= written_reg + CNT_ONE;
                    if (last_commit) state_reg   <= ST_DONE;
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            mem_we_reg <= pop;
            if (pop) begin
                mem_addr_reg  <= base_reg + popped_reg;
                mem_wdata_reg <= fifo_head;
            end
        end
    end

    assign o_mem_we    = mem_we_reg;
    assign o_mem_addr  = mem_addr_reg;
    assign o_mem_wdata = mem_wdata_reg;
    assign o_busy      = (state_reg == ST_LOAD);
    assign o_done      = (state_reg == ST_DONE);

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: depth of the field buffer; a power of two, at least 2.
REQ-002 Parameter ADDR_W, default 8: width of the instruction-memory address.
REQ-003 i_clk  in  1  single clock; every register updates on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous and active-high.
REQ-005 i_start  in  1  one-cycle request to start a program load.
REQ-006 i_base_addr  in  ADDR_W  first write address, sampled with i_start.
REQ-007 i_len  in  ADDR_W  number of instructions to load, sampled with i_start.
REQ-008 i_valid  in  1  field set is valid.
REQ-009 o_ready  out  1  block can accept a field set.
REQ-010 i_opcode, i_srcadd_1, i_srcadd_2, i_destadd  in  4 each  instruction fields.
REQ-011 o_mem_we  out  1  instruction-memory write strobe.
REQ-012 o_mem_addr  out  ADDR_W  write address.
REQ-013 o_mem_wdata  out  16  packed instruction word.
REQ-014 o_busy  out  1  high in LOAD state.
REQ-015 o_done  out  1  one-cycle pulse when a load completes.

Function
REQ-016 Pack order SHALL be: wdata[15:12]=opcode, [11:8]=srcadd_1, [7:4]=srcadd_2, [3:0]=destadd.
REQ-017 The FSM SHALL have three states: IDLE, LOAD and DONE.
- IDLE->LOAD: on i_start with i_len != 0; latches base and len, clears the accepted and written counters.
- IDLE->DONE: on i_start with i_len == 0.
- LOAD->DONE: on the edge that commits the write with written == len-1.
- DONE->IDLE: unconditionally, after one cycle.
REQ-018 i_start SHALL be ignored outside IDLE.
REQ-019 o_ready SHALL be registered-state combinational: state==LOAD, FIFO not full, and accepted < len; it never depends on i_valid.
REQ-020 A field set SHALL be accepted on a rising edge where i_valid && o_ready; it is packed and pushed into the FIFO.
REQ-021 In LOAD with the FIFO non-empty, the head SHALL be popped every edge and written to memory.
- Write outputs are registered: o_mem_we=1, o_mem_wdata=head, o_mem_addr=base+written (modulo 2^ADDR_W).
- o_mem_we is high for exactly one cycle per pop.
REQ-022 Latency: a set accepted at edge E into an empty FIFO SHALL produce o_mem_we=1 between edges E+1 and E+2; throughput SHALL be one word per cycle.
REQ-023 A simultaneous push and pop SHALL leave the occupancy unchanged; a push is refused while full, even if a pop occurs in the same cycle.
REQ-024 Address wrap SHALL be silent (0xFF+1 -> 0x00 for ADDR_W=8).
REQ-025 o_done SHALL be high only in the DONE state, exactly one cycle.
- For a non-empty load, this is the cycle right after the last o_mem_we cycle.
REQ-026 Words written SHALL equal i_len exactly; extra i_valid is never accepted.

Reset
REQ-027 i_rst SHALL asynchronously force:
- state=IDLE, FIFO empty, counters and latched base/len = 0;
- o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_ready=0, o_busy=0, o_done=0.
REQ-028 Reset during LOAD SHALL abort the load; no further writes occur, and buffered words are discarded.

Structure
REQ-029 The field widths (4), the instruction width (16) and the field bit positions SHALL live in a shared ISA package, also used by the decode stage.
REQ-030 The buffer SHALL be one sub-module, sync_fifo (parameterised width and depth; push, pop, full, empty), instantiated once.

Verification
REQ-031 Basic load: start base=0x10, len=3; push 0x1, 0x2, 0x3, 0x4 then 0x5, 0x6, 0x7, 0x8 then 0xA, 0xB, 0xC, 0xD back-to-back -> writes 0x1234@0x10, 0x5678@0x11, 0xABCD@0x12; first o_mem_we one cycle after the first accept; o_done one cycle after the last write.
REQ-032 Zero length: start with len=0 -> o_done pulses in the next cycle, o_ready never asserts, no writes occur.
REQ-033 Wrap: base=0xFE, len=4 -> write addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-034 Backpressure and overrun: len=4; hold i_valid high for 6 cycles -> exactly 4 accepts; o_ready low after the 4th accept; FIFO never overflows.
REQ-035 Reset mid-load: len=8; assert i_rst after 3 writes -> all outputs reset immediately and no o_mem_we after release; a new start then loads correctly.
REQ-036 Start while busy: pulse i_start during LOAD with different base and len -> ignored; the original load completes unchanged.
